rs_age_param: RTL and testbench

- Parametrised successor to the single-issue ALU reservation station.
- Generalised in depth, tag/data/opcode width and number of CDB broadcast channels.
- Adds oldest-first issue selection, a valid/ready issue handshake toward the ALU, and an occupancy count.
- Sits between decode/dispatch and the ALU; listens to every CDB; flushed by ROB misbranch.

---
 rtl/rs_age_param_pkg.sv | 17 +
 rtl/rs_oldest_sel.sv | 37 +++
 rtl/rs_age_param.sv | 227 ++++++++++++++++++++++
 tb/tb_rs_age_param.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_age_param_pkg.sv
// Shared constants for the age-ordered reservation station and its oldest-first selector.
package rs_age_param_pkg;

    localparam int DEF_RS_DEPTH  = 16;
    localparam int DEF_ROB_TAG_W = 4;
    localparam int DEF_DATA_W    = 32;
    localparam int DEF_OP_W      = 6;
    localparam int DEF_NUM_CDB   = 3;
    localparam int DEF_NOP_OP    = 0;
    localparam int ZERO_TAG      = 0;

    // Bit offset of CDB channel ch inside a packed bus of width-bit fields.
    function automatic int cdb_lsb(input int ch, input int width);
        return ch * width;
    endfunction

endpackage

// File: rtl/rs_oldest_sel.sv
// Oldest-first grant over a ready vector using an age matrix; i_age[j*N+i]=1 means j is older than i.
module rs_oldest_sel #(
    parameter int N     = 16,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_ready,
    input  logic [N*N-1:0]   i_age,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    logic [N-1:0] w_older [N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                w_older[i][j] = (i != j) && i_age[j*N + i];
            end
        end
    end

    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        for (int i = 0; i < N; i++) begin
            o_grant[i] = i_ready[i] && !(|(i_ready & w_older[i]));
            if (o_grant[i]) begin
                o_idx = o_idx | IDX_W'(i);
            end
        end
    end

    assign o_any = |i_ready;

endmodule

// File: rtl/rs_age_param.sv
// Parametrised ALU reservation station: CDB wakeup with allocate-time bypass, oldest-first issue
// into a valid/ready issue register, occupancy count, misbranch flush.
module rs_age_param
    import rs_age_param_pkg::*;
#(
    parameter int RS_DEPTH  = DEF_RS_DEPTH,
    parameter int ROB_TAG_W = DEF_ROB_TAG_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int OP_W      = DEF_OP_W,
    parameter int NUM_CDB   = DEF_NUM_CDB,
    parameter int NOP_OP    = DEF_NOP_OP
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rdy,
    input  logic                          alloc_valid,
    output logic                          alloc_ready,
    input  logic [ROB_TAG_W-1:0]          alloc_rob_tag,
    input  logic [OP_W-1:0]               alloc_op,
    input  logic [DATA_W-1:0]             alloc_v1,
    input  logic [DATA_W-1:0]             alloc_v2,
    input  logic [DATA_W-1:0]             alloc_imm,
    input  logic [DATA_W-1:0]             alloc_pc,
    input  logic [ROB_TAG_W-1:0]          alloc_q1,
    input  logic [ROB_TAG_W-1:0]          alloc_q2,
    input  logic [NUM_CDB-1:0]            cdb_valid,
    input  logic [NUM_CDB*ROB_TAG_W-1:0]  cdb_tag,
    input  logic [NUM_CDB*DATA_W-1:0]     cdb_value,
    input  logic                          flush,
    output logic                          issue_valid,
    input  logic                          issue_ready,
    output logic [OP_W-1:0]               issue_op,
    output logic [DATA_W-1:0]             issue_v1,
    output logic [DATA_W-1:0]             issue_v2,
    output logic [DATA_W-1:0]             issue_imm,
    output logic [DATA_W-1:0]             issue_pc,
    output logic [ROB_TAG_W-1:0]          issue_rob_tag,
    output logic [$clog2(RS_DEPTH):0]     count
);

    localparam int IDX_W = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;
    localparam int CNT_W = $clog2(RS_DEPTH) + 1;
    localparam logic [OP_W-1:0]      L_NOP  = OP_W'(NOP_OP);
    localparam logic [ROB_TAG_W-1:0] L_ZTAG = ROB_TAG_W'(ZERO_TAG);

    logic [RS_DEPTH-1:0]          r_busy;
    logic [RS_DEPTH*RS_DEPTH-1:0] r_age;
    logic [OP_W-1:0]              r_op  [RS_DEPTH];
    logic [DATA_W-1:0]            r_v1  [RS_DEPTH];
    logic [DATA_W-1:0]            r_v2  [RS_DEPTH];
    logic [DATA_W-1:0]            r_imm [RS_DEPTH];
    logic [DATA_W-1:0]            r_pc  [RS_DEPTH];
    logic [ROB_TAG_W-1:0]         r_tag [RS_DEPTH];
    logic [ROB_TAG_W-1:0]         r_q1  [RS_DEPTH];
    logic [ROB_TAG_W-1:0]         r_q2  [RS_DEPTH];

    logic                 r_issue_valid;
    logic [OP_W-1:0]      r_issue_op;
    logic [DATA_W-1:0]    r_issue_v1, r_issue_v2, r_issue_imm, r_issue_pc;
    logic [ROB_TAG_W-1:0] r_issue_rob_tag;

    logic [ROB_TAG_W-1:0] w_cdb_tag [NUM_CDB];
    logic [DATA_W-1:0]    w_cdb_val [NUM_CDB];

    logic [ROB_TAG_W-1:0] w_q1_nx [RS_DEPTH];
    logic [ROB_TAG_W-1:0] w_q2_nx [RS_DEPTH];
    logic [DATA_W-1:0]    w_v1_nx [RS_DEPTH];
    logic [DATA_W-1:0]    w_v2_nx [RS_DEPTH];
    logic [ROB_TAG_W-1:0] w_aq1, w_aq2;
    logic [DATA_W-1:0]    w_av1, w_av2;

    logic [RS_DEPTH-1:0]          w_ready, w_grant, w_free_mask, w_alloc_mask;
    logic [RS_DEPTH*RS_DEPTH-1:0] w_age_nx;
    logic [IDX_W-1:0]             w_free_idx, w_sel_idx;
    logic [CNT_W-1:0]             w_count;
    logic                         w_any, w_load, w_alloc_fire;

    for (genvar k = 0; k < NUM_CDB; k++) begin : g_cdb
        assign w_cdb_tag[k] = cdb_tag[cdb_lsb(k, ROB_TAG_W) +: ROB_TAG_W];
        assign w_cdb_val[k] = cdb_value[cdb_lsb(k, DATA_W) +: DATA_W];
    end

    // Returns {q, v} after snooping the CDB; descending scan lets the lowest matching channel win.
    function automatic logic [ROB_TAG_W+DATA_W-1:0] snoop(
        input logic [ROB_TAG_W-1:0] q,
        input logic [DATA_W-1:0]    v
    );
        logic [ROB_TAG_W-1:0] q_o;
        logic [DATA_W-1:0]    v_o;
        q_o = q;
        v_o = v;
        for (int k = NUM_CDB - 1; k >= 0; k--) begin
            if (q != L_ZTAG && cdb_valid[k] && w_cdb_tag[k] == q) begin
                q_o = L_ZTAG;
                v_o = w_cdb_val[k];
            end
        end
        return {q_o, v_o};
    endfunction

    always_comb begin
        for (int e = 0; e < RS_DEPTH; e++) begin
            {w_q1_nx[e], w_v1_nx[e]} = snoop(r_q1[e], r_v1[e]);
            {w_q2_nx[e], w_v2_nx[e]} = snoop(r_q2[e], r_v2[e]);
        end
        {w_aq1, w_av1} = snoop(alloc_q1, alloc_v1);
        {w_aq2, w_av2} = snoop(alloc_q2, alloc_v2);
    end

    always_comb begin
        w_free_idx = '0;
        w_count    = '0;
        w_ready    = '0;
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (!r_busy[i]) w_free_idx = IDX_W'(i);
        end
        for (int i = 0; i < RS_DEPTH; i++) begin
            w_ready[i] = r_busy[i] && (r_q1[i] == L_ZTAG) && (r_q2[i] == L_ZTAG);
            w_count    = w_count + CNT_W'(r_busy[i]);
        end
    end

    assign alloc_ready  = (w_count < CNT_W'(RS_DEPTH));
    assign count        = w_count;
    assign w_alloc_fire = alloc_valid && alloc_ready && (alloc_op != L_NOP) && (alloc_rob_tag != L_ZTAG);

    rs_oldest_sel #(
        .N     (RS_DEPTH),
        .IDX_W (IDX_W)
    ) u_sel (
        .i_ready (w_ready),
        .i_age   (r_age),
        .o_grant (w_grant),
        .o_idx   (w_sel_idx),
        .o_any   (w_any)
    );

    assign w_load = (!r_issue_valid || issue_ready) && w_any;

    always_comb begin
        w_alloc_mask = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            w_alloc_mask[i] = w_alloc_fire && (w_free_idx == IDX_W'(i));
        end
        w_free_mask = w_load ? w_grant : '0;
    end

    // A new entry is younger than every entry that survives this edge.
    always_comb begin
        w_age_nx = r_age;
        for (int i = 0; i < RS_DEPTH; i++) begin
            for (int j = 0; j < RS_DEPTH; j++) begin
                if (w_free_mask[i] || w_free_mask[j]) w_age_nx[i*RS_DEPTH + j] = 1'b0;
                if (w_alloc_mask[j]) w_age_nx[i*RS_DEPTH + j] = r_busy[i] && !w_free_mask[i];
                if (w_alloc_mask[i]) w_age_nx[i*RS_DEPTH + j] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy          <= '0;
            r_age           <= '0;
            r_issue_valid   <= 1'b0;
            r_issue_op      <= L_NOP;
            r_issue_v1      <= '0;
            r_issue_v2      <= '0;
            r_issue_imm     <= '0;
            r_issue_pc      <= '0;
            r_issue_rob_tag <= '0;
        end else if (rdy) begin
            if (flush) begin
                r_busy        <= '0;
                r_age         <= '0;
                r_issue_valid <= 1'b0;
                r_issue_op    <= L_NOP;
            end else begin
                r_busy <= (r_busy & ~w_free_mask) | w_alloc_mask;
                r_age  <= w_age_nx;
                if (w_load) begin
                    r_issue_valid   <= 1'b1;
                    r_issue_op      <= r_op[w_sel_idx];
                    r_issue_v1      <= r_v1[w_sel_idx];
                    r_issue_v2      <= r_v2[w_sel_idx];
                    r_issue_imm     <= r_imm[w_sel_idx];
                    r_issue_pc      <= r_pc[w_sel_idx];
                    r_issue_rob_tag <= r_tag[w_sel_idx];
                end else if (issue_ready) begin
                    r_issue_valid <= 1'b0;
                    r_issue_op    <= L_NOP;
                end
            end
        end
    end

    // NOTE: entry payload is only meaningful while r_busy is set, so this storage carries no reset.
    always_ff @(posedge clk) begin
        if (rdy) begin
            for (int e = 0; e < RS_DEPTH; e++) begin
                if (w_alloc_mask[e]) begin
                    r_op[e]  <= alloc_op;
                    r_tag[e] <= alloc_rob_tag;
                    r_imm[e] <= alloc_imm;
                    r_pc[e]  <= alloc_pc;
                    r_q1[e]  <= w_aq1;
                    r_v1[e]  <= w_av1;
                    r_q2[e]  <= w_aq2;
                    r_v2[e]  <= w_av2;
                end else if (r_busy[e]) begin
                    r_q1[e] <= w_q1_nx[e];
                    r_v1[e] <= w_v1_nx[e];
                    r_q2[e] <= w_q2_nx[e];
                    r_v2[e] <= w_v2_nx[e];
                end
            end
        end
    end

    assign issue_valid   = r_issue_valid;
    assign issue_op      = r_issue_op;
    assign issue_v1      = r_issue_v1;
    assign issue_v2      = r_issue_v2;
    assign issue_imm     = r_issue_imm;
    assign issue_pc      = r_issue_pc;
    assign issue_rob_tag = r_issue_rob_tag;

endmodule

// File: tb/tb_rs_age_param.sv
// Randomised bench for rs_age_param: an in-order list model predicts each issued payload into a
// scoreboard queue; a negedge monitor compares DUT handshakes, count and valid against it.
module tb_rs_age_param;

    localparam int DEPTH = 16;
    localparam int TW    = 4;
    localparam int DW    = 32;
    localparam int OW    = 6;
    localparam int NC    = 3;

    logic              clk = 1'b0;
    logic              rst, rdy, flush;
    logic              alloc_valid, alloc_ready;
    logic [TW-1:0]     alloc_rob_tag, alloc_q1, alloc_q2;
    logic [OW-1:0]     alloc_op;
    logic [DW-1:0]     alloc_v1, alloc_v2, alloc_imm, alloc_pc;
    logic [NC-1:0]     cdb_valid;
    logic [NC*TW-1:0]  cdb_tag;
    logic [NC*DW-1:0]  cdb_value;
    logic              issue_valid, issue_ready;
    logic [OW-1:0]     issue_op;
    logic [DW-1:0]     issue_v1, issue_v2, issue_imm, issue_pc;
    logic [TW-1:0]     issue_rob_tag;
    logic [$clog2(DEPTH):0] count;

    always #5 clk = ~clk;

    rs_age_param #(
        .RS_DEPTH(DEPTH), .ROB_TAG_W(TW), .DATA_W(DW), .OP_W(OW), .NUM_CDB(NC), .NOP_OP(0)
    ) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_rob_tag(alloc_rob_tag),
        .alloc_op(alloc_op), .alloc_v1(alloc_v1), .alloc_v2(alloc_v2), .alloc_imm(alloc_imm),
        .alloc_pc(alloc_pc), .alloc_q1(alloc_q1), .alloc_q2(alloc_q2),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value), .flush(flush),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
        .issue_v1(issue_v1), .issue_v2(issue_v2), .issue_imm(issue_imm), .issue_pc(issue_pc),
        .issue_rob_tag(issue_rob_tag), .count(count)
    );

    typedef struct {
        logic [OW-1:0] op;
        logic [DW-1:0] v1, v2, imm, pc;
        logic [TW-1:0] tag, q1, q2;
    } ent_t;

    ent_t m_list[$];   // waiting instructions, oldest first
    ent_t exp_q[$];    // payloads predicted to be sitting in the issue register
    bit   m_iv = 1'b0;
    bit   mon_en = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Operand after this edge's CDB: first valid channel carrying the awaited tag supplies the value.
    function automatic logic [TW+DW-1:0] wake(input logic [TW-1:0] q, input logic [DW-1:0] v);
        if (q != 0) begin
            for (int k = 0; k < NC; k++) begin
                if (cdb_valid[k] && cdb_tag[k*TW +: TW] == q) return {TW'(0), cdb_value[k*DW +: DW]};
            end
        end
        return {q, v};
    endfunction

    task automatic model_step();
        int sz, sel;
        ent_t e;
        logic [TW+DW-1:0] r;
        if (rst) begin
            m_list.delete(); exp_q.delete(); m_iv = 1'b0;
            return;
        end
        if (!rdy) return;
        if (flush) begin
            m_list.delete(); exp_q.delete(); m_iv = 1'b0;
            return;
        end
        sz  = m_list.size();
        sel = -1;
        foreach (m_list[i]) if (sel < 0 && m_list[i].q1 == 0 && m_list[i].q2 == 0) sel = i;
        if ((!m_iv || issue_ready) && sel >= 0) begin
            exp_q.push_back(m_list[sel]);
            m_list.delete(sel);
            m_iv = 1'b1;
        end else if (issue_ready) begin
            m_iv = 1'b0;
        end
        foreach (m_list[i]) begin
            r = wake(m_list[i].q1, m_list[i].v1);
            m_list[i].q1 = r[DW +: TW]; m_list[i].v1 = r[DW-1:0];
            r = wake(m_list[i].q2, m_list[i].v2);
            m_list[i].q2 = r[DW +: TW]; m_list[i].v2 = r[DW-1:0];
        end
        if (alloc_valid && sz < DEPTH && alloc_op != 0 && alloc_rob_tag != 0) begin
            e.op = alloc_op; e.tag = alloc_rob_tag; e.imm = alloc_imm; e.pc = alloc_pc;
            r = wake(alloc_q1, alloc_v1);
            e.q1 = r[DW +: TW]; e.v1 = r[DW-1:0];
            r = wake(alloc_q2, alloc_v2);
            e.q2 = r[DW +: TW]; e.v2 = r[DW-1:0];
            m_list.push_back(e);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    initial begin : monitor
        ent_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                check("count", count, m_list.size());
                check("alloc_ready", alloc_ready, m_list.size() < DEPTH);
                check("issue_valid", issue_valid, m_iv);
                if (!issue_valid) check("issue_op_nop", issue_op, 0);
                if (issue_valid && issue_ready && rdy && !flush) begin
                    if (exp_q.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL unexpected_issue: actual tag=%0h required no issue", issue_rob_tag);
                    end else begin
                        e = exp_q.pop_front();
                        check("payload", {issue_op, issue_v1, issue_v2, issue_imm, issue_pc, issue_rob_tag},
                              {e.op, e.v1, e.v2, e.imm, e.pc, e.tag});
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "bench timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc_valid = 1'b0; alloc_op = '0; alloc_rob_tag = '0;
        alloc_v1 = '0; alloc_v2 = '0; alloc_imm = '0; alloc_pc = '0;
        alloc_q1 = '0; alloc_q2 = '0;
        cdb_valid = '0; cdb_tag = '0; cdb_value = '0;
        flush = 1'b0;
    endtask

    task automatic alloc(input logic [TW-1:0] tag, input logic [DW-1:0] v1, input logic [TW-1:0] q1,
                         input logic [DW-1:0] v2, input logic [TW-1:0] q2);
        alloc_valid = 1'b1; alloc_op = 6'd1; alloc_rob_tag = tag;
        alloc_v1 = v1; alloc_q1 = q1; alloc_v2 = v2; alloc_q2 = q2;
        alloc_imm = {28'h0, tag}; alloc_pc = 32'h1000 + {28'h0, tag};
    endtask

    initial begin : stimulus
        rst = 1'b1; rdy = 1'b1; issue_ready = 1'b1;
        idle();
        tick(); tick();
        check("rst_count", count, 0);
        check("rst_alloc_ready", alloc_ready, 1);
        check("rst_issue_valid", issue_valid, 0);
        check("rst_issue_op", issue_op, 0);
        check("rst_issue_data", {issue_v1, issue_v2, issue_imm, issue_pc, issue_rob_tag}, 0);
        rst = 1'b0;
        mon_en = 1'b1;

        // Single ready instruction: issues one edge after allocation.
        alloc(4'd3, 32'd5, 4'd0, 32'd7, 4'd0);
        tick(); idle();
        check("t1_count1", count, 1);
        check("t1_not_yet", issue_valid, 0);
        tick();
        check("t1_valid", issue_valid, 1);
        check("t1_v1v2", {issue_v1, issue_v2}, {32'd5, 32'd7});
        check("t1_tag", issue_rob_tag, 3);
        check("t1_count0", count, 0);
        tick();

        // Younger ready B overtakes waiting A; A then issues with the CDB value.
        alloc(4'd1, 32'd0, 4'd4, 32'd2, 4'd0);
        tick();
        alloc(4'd2, 32'h22, 4'd0, 32'd3, 4'd0);
        tick(); idle();
        cdb_valid = 3'b100; cdb_tag = {4'd4, 4'd0, 4'd0}; cdb_value = {32'h99, 64'h0};
        tick(); idle();
        check("t2_b_first", issue_rob_tag, 2);
        tick();
        check("t2_a_second", issue_rob_tag, 1);
        check("t2_a_v1", issue_v1, 32'h99);
        tick();

        // Allocate-time bypass on operand 2.
        alloc(4'd5, 32'd1, 4'd0, 32'd0, 4'd6);
        cdb_valid = 3'b001; cdb_tag = {4'd0, 4'd0, 4'd6}; cdb_value = {64'h0, 32'h11};
        tick(); idle();
        tick();
        check("t3_valid", issue_valid, 1);
        check("t3_v2", issue_v2, 32'h11);
        check("t3_tag", issue_rob_tag, 5);
        tick(); tick();

        // Fill under backpressure, drop extra allocations, then drain in allocation order.
        issue_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            alloc(TW'((i % 15) + 1), DW'(i), 4'd0, 32'd0, 4'd0);
            tick();
        end
        check("t4_full_count", count, 16);
        check("t4_full_ready", alloc_ready, 0);
        for (int c = 0; c < 5; c++) begin
            alloc(4'd7, 32'hdead, 4'd0, 32'd0, 4'd0);
            tick();
            check("t4_hold_count", count, 16);
            check("t4_hold_payload", {issue_rob_tag, issue_v1}, {4'd1, 32'd0});
        end
        idle();
        issue_ready = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            check("t4_order", {issue_rob_tag, issue_v1}, {TW'((k % 15) + 1), DW'(k)});
        end
        tick();
        check("t4_empty", issue_valid, 0);

        // Flush with a pending issue and a same-cycle allocation.
        issue_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            alloc(TW'(i + 1), DW'(100 + i), 4'd0, 32'd0, 4'd0);
            tick();
        end
        check("t5_count5", count, 5);
        check("t5_pending", issue_valid, 1);
        alloc(4'd9, 32'd1, 4'd0, 32'd0, 4'd0);
        flush = 1'b1;
        tick(); idle();
        issue_ready = 1'b1;
        check("t5_flush_count", count, 0);
        check("t5_flush_valid", issue_valid, 0);
        check("t5_flush_op", issue_op, 0);
        tick();
        check("t5_not_stored", count, 0);

        // rdy low freezes everything; the same broadcast after rdy returns wakes the entry.
        alloc(4'd2, 32'd0, 4'd9, 32'd4, 4'd0);
        tick();
        rdy = 1'b0;
        alloc(4'd3, 32'd1, 4'd0, 32'd1, 4'd0);
        cdb_valid = 3'b001; cdb_tag = {4'd0, 4'd0, 4'd9}; cdb_value = {64'h0, 32'h55};
        for (int c = 0; c < 3; c++) begin
            tick();
            check("t6_frozen_count", count, 1);
            check("t6_frozen_valid", issue_valid, 0);
        end
        rdy = 1'b1;
        alloc_valid = 1'b0;
        tick(); idle();
        tick();
        check("t6_woken", {issue_valid, issue_rob_tag, issue_v1}, {1'b1, 4'd2, 32'h55});
        tick();

        // Randomised traffic.
        for (int c = 0; c < 2000; c++) begin
            alloc_valid   = ($urandom_range(0, 9) < 6);
            alloc_op      = ($urandom_range(0, 9) == 0) ? 6'd0 : OW'($urandom_range(1, 63));
            alloc_rob_tag = TW'($urandom_range(0, 15));
            alloc_v1      = $urandom; alloc_v2 = $urandom;
            alloc_imm     = $urandom; alloc_pc = $urandom;
            alloc_q1      = ($urandom_range(0, 1) == 0) ? 4'd0 : TW'($urandom_range(1, 15));
            alloc_q2      = ($urandom_range(0, 1) == 0) ? 4'd0 : TW'($urandom_range(1, 15));
            for (int k = 0; k < NC; k++) begin
                cdb_valid[k]          = ($urandom_range(0, 1) == 1);
                cdb_tag[k*TW +: TW]   = TW'($urandom_range(0, 15));
                cdb_value[k*DW +: DW] = $urandom;
            end
            issue_ready = ($urandom_range(0, 9) < 7);
            flush       = ($urandom_range(0, 99) == 0);
            rdy         = ($urandom_range(0, 9) != 0);
            tick();
        end

        // Drain: broadcast every tag so all waiting entries resolve and issue.
        idle();
        rdy = 1'b1;
        issue_ready = 1'b1;
        for (int t = 1; t <= 45; t++) begin
            cdb_valid = 3'b001;
            cdb_tag   = {8'h0, TW'((t % 15) + 1)};
            cdb_value = {64'h0, DW'($urandom)};
            tick();
        end
        idle();
        for (int c = 0; c < 40; c++) tick();
        check("final_count", count, 0);
        check("final_valid", issue_valid, 0);
        check("final_scoreboard", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
